// File: rtl/mux_flop_stage.sv
// mux_flop_stage: 4:1 input mux -> enabled register with async active-low reset -> 2:1 output mux.
// Optional feature macro MUX_FLOP_STAGE_LOAD_FLAG_EN adds a registered `loaded` flag output.

module mux2 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? b : a;
endmodule

module mux4 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    // NOTE: assign a default before the case so no path leaves y unassigned (no latch).
    y = a;
    case (s)
      2'b00: y = a;
      2'b01: y = b;
      2'b10: y = c;
      2'b11: y = d;
    endcase
  end
endmodule

module flop_en_ar #(
  parameter int             WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignment; reset is in the sensitivity list so it acts without a clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  r_q <= RESET_VALUE;
    else if (en) r_q <= d;
  end

  assign q = r_q;
endmodule

module mux_flop_stage #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       select,
  input  logic             enable,
  input  logic             bypass,
`ifdef MUX_FLOP_STAGE_LOAD_FLAG_EN
  output logic             loaded,
`endif
  output logic [WIDTH-1:0] selected,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] w_selected;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_y;

  mux4 #(.WIDTH(WIDTH)) u_mux4 (
    .a(d0), .b(d1), .c(d2), .d(d3), .s(select), .y(w_selected)
  );

  flop_en_ar #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_flop (
    .clock(clock), .reset(reset), .en(enable), .d(w_selected), .q(w_q)
  );

  // bypass=1 exposes the value the next enabling edge would capture.
  mux2 #(.WIDTH(WIDTH)) u_mux2 (
    .a(w_q), .b(w_selected), .s(bypass), .y(w_y)
  );

  assign selected = w_selected;
  assign q        = w_q;
  assign y        = w_y;

`ifdef MUX_FLOP_STAGE_LOAD_FLAG_EN
  logic r_loaded;

  // Marks that q was written on the most recent edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_loaded <= 1'b0;
    else        r_loaded <= enable;
  end

  assign loaded = r_loaded;
`endif
endmodule

// File: tb/tb_mux_flop_stage.sv
// Self-checking bench for mux_flop_stage: directed test-plan scenarios plus random traffic,
// checked through an expected-value queue drained by an independent monitor.

module tb_mux_flop_stage;
  localparam int          W   = 16;
  localparam logic [W-1:0] RV = 16'h0000;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] d0, d1, d2, d3;
  logic [1:0]   select;
  logic         enable, bypass;
  logic [W-1:0] selected, q, y;
  logic         loaded;

  always #5 clock = ~clock;

  mux_flop_stage #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clock(clock), .reset(reset),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .select(select), .enable(enable), .bypass(bypass),
`ifdef MUX_FLOP_STAGE_LOAD_FLAG_EN
    .loaded(loaded),
`endif
    .selected(selected), .q(q), .y(y)
  );

`ifndef MUX_FLOP_STAGE_LOAD_FLAG_EN
  assign loaded = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] y;
    logic         loaded;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: value held by the stage and the "updated last edge" flag.
  logic [W-1:0] m_q      = RV;
  logic         m_loaded = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus between edges, check the zero-latency outputs,
  // then queue what the model predicts right after the following rising edge.
  task automatic step(input logic rst_v, input logic en, input logic [1:0] sel, input logic byp,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] d);
    logic [W-1:0] dv [4];
    logic [W-1:0] pick;
    exp_t e;
    @(negedge clock);
    #1;
    reset = rst_v; enable = en; select = sel; bypass = byp;
    d0 = a; d1 = b; d2 = c; d3 = d;
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
    pick = dv[sel];
    if (!rst_v) begin
      m_q      = RV;
      m_loaded = 1'b0;
    end
    #1;
    check("selected_comb", selected, pick);
    check("q_now", q, m_q);
    check("y_comb", y, byp ? pick : m_q);
`ifdef MUX_FLOP_STAGE_LOAD_FLAG_EN
    check("loaded_now", loaded, m_loaded);
`endif
    if (!rst_v) begin
      m_q      = RV;
      m_loaded = 1'b0;
    end else begin
      if (en) m_q = pick;
      m_loaded = en;
    end
    e.q      = m_q;
    e.y      = byp ? pick : m_q;
    e.loaded = m_loaded;
    sb.push_back(e);
  endtask

  // Monitor: after each rising edge, compare registered results with the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("q_edge", q, e.q);
        check("y_edge", y, e.y);
`ifdef MUX_FLOP_STAGE_LOAD_FLAG_EN
        check("loaded_edge", loaded, e.loaded);
`endif
      end
    end
  end

  initial begin
    int waitc;
    // Reset state before any clock edge.
    reset = 1'b0; enable = 1'b1; select = 2'b00; bypass = 1'b0;
    d0 = 16'h1234; d1 = 16'h0; d2 = 16'h0; d3 = 16'h0;
    #1;
    check("rst_q", q, 16'h0000);
    check("rst_y", y, 16'h0000);
    check("rst_selected", selected, 16'h1234);
    repeat (3) step(1'b0, 1'b1, 2'b00, 1'b0, 16'h1234, 16'h0, 16'h0, 16'h0);
    step(1'b0, 1'b1, 2'b00, 1'b1, 16'h1234, 16'h0, 16'h0, 16'h0);

    // Select sweep with loads.
    for (int s = 0; s < 4; s++)
      step(1'b1, 1'b1, 2'(s), 1'b0, 16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0);

    // Hold.
    step(1'b1, 1'b1, 2'b00, 1'b0, 16'hBEEF, 16'h1111, 16'h2222, 16'h3333);
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'b0,
           16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));

    // Bypass.
    step(1'b1, 1'b1, 2'b01, 1'b0, 16'h0000, 16'h0001, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 2'b10, 1'b1, 16'h0000, 16'h0001, 16'h7FFF, 16'h0000);
    step(1'b1, 1'b0, 2'b10, 1'b0, 16'h0000, 16'h0001, 16'h7FFF, 16'h0000);

    // Async reset mid-run: assert between edges and observe q before any edge.
    step(1'b1, 1'b1, 2'b11, 1'b0, 16'h0, 16'h0, 16'h0, 16'hCAFE);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_q", q, RV);
    check("async_rst_y", y, RV);
    check("async_rst_selected", selected, 16'hCAFE);
    m_q = RV; m_loaded = 1'b0;
    step(1'b0, 1'b1, 2'b01, 1'b1, 16'h0, 16'h0042, 16'h0, 16'h0);
    step(1'b1, 1'b1, 2'b01, 1'b0, 16'h0, 16'h0042, 16'h0, 16'h0);

    // Load-flag enable pattern 1,1,0,1.
    step(1'b1, 1'b1, 2'b00, 1'b0, 16'h0101, 16'h0, 16'h0, 16'h0);
    step(1'b1, 1'b1, 2'b00, 1'b0, 16'h0202, 16'h0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 2'b00, 1'b0, 16'h0303, 16'h0, 16'h0, 16'h0);
    step(1'b1, 1'b1, 2'b00, 1'b0, 16'h0404, 16'h0, 16'h0, 16'h0);

    // Random traffic with occasional reset cycles.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 15) != 0), 1'($urandom), 2'($urandom), 1'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));

    // Let the monitor drain the queue, bounded.
    waitc = 0;
    while (sb.size() != 0 && waitc < 20) begin
      @(posedge clock);
      #3;
      waitc++;
    end
    check("scoreboard_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
